// File: rtl/fcb_sfr_arb_if.sv
`default_nettype none
//==============================================================================
// Module      : fcb_sfr_arb_if
// Description : Bus bundle of the FCB SFR/CWF arbiter. It carries both
//               requester ports (r0 = SPI-slave bridge, r1 = MCU/fmic), the
//               shared read-data return and the FRFU-side SFR/CWF strobes.
//   modport slave  : arbiter view (takes requests and FRFU status, drives
//                    acks, read data and FRFU strobes)
//   modport master : environment view (requesters plus FRFU model)
// Revision    : 1.0 - initial release
//==============================================================================
interface fcb_sfr_arb_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
);
   // requester 0 (SPI-slave bridge)
   logic              r0_req;
   logic              r0_we;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata;
   logic              r0_ack;
   logic              r0_err;
   // requester 1 (MCU/fmic register path)
   logic              r1_req;
   logic              r1_we;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata;
   logic              r1_ack;
   logic              r1_err;
   // shared read return
   logic [DATA_W-1:0] rd_data;
   // FRFU side
   logic [DATA_W-1:0] frfu_sfr_rd_data;
   logic              frfu_cwf_full;
   logic              farb_frfu_wr_en;
   logic [ADDR_W-1:0] farb_frfu_wr_addr;
   logic [DATA_W-1:0] farb_frfu_wr_data;
   logic              farb_frfu_rd_en;
   logic [ADDR_W-1:0] farb_frfu_rd_addr;
   logic              farb_frfu_cwf_wr_en;
   logic [DATA_W-1:0] farb_frfu_cwf_wr_data;
   logic              farb_busy;
   logic              farb_cwf_tmo_err;

   modport slave (
      input  r0_req, r0_we, r0_addr, r0_wdata,
      input  r1_req, r1_we, r1_addr, r1_wdata,
      input  frfu_sfr_rd_data, frfu_cwf_full,
      output r0_ack, r0_err, r1_ack, r1_err, rd_data,
      output farb_frfu_wr_en, farb_frfu_wr_addr, farb_frfu_wr_data,
      output farb_frfu_rd_en, farb_frfu_rd_addr,
      output farb_frfu_cwf_wr_en, farb_frfu_cwf_wr_data,
      output farb_busy, farb_cwf_tmo_err
   );

   modport master (
      output r0_req, r0_we, r0_addr, r0_wdata,
      output r1_req, r1_we, r1_addr, r1_wdata,
      output frfu_sfr_rd_data, frfu_cwf_full,
      input  r0_ack, r0_err, r1_ack, r1_err, rd_data,
      input  farb_frfu_wr_en, farb_frfu_wr_addr, farb_frfu_wr_data,
      input  farb_frfu_rd_en, farb_frfu_rd_addr,
      input  farb_frfu_cwf_wr_en, farb_frfu_cwf_wr_data,
      input  farb_busy, farb_cwf_tmo_err
   );
endinterface
`default_nettype wire

// File: rtl/fcb_sfr_arb.sv
`default_nettype none
//==============================================================================
// Module      : fcb_sfr_arb
// Description : Serialises SFR/CWF accesses from two requesters (r0 = SPI-slave
//               bridge, r1 = MCU/fmic). One transaction at a time, round-robin
//               on contention. Writes to CWF_ADDR go to the config write FIFO
//               and stall while it is full; everything else uses the SFR port.
// Ports       : fcb_sys_clk   - FCB system clock
//               fcb_sys_rst_n - synchronous active-low reset
//               bus           - fcb_sfr_arb_if.slave (requesters + FRFU side)
// Option      : FCB_SFR_ARB_CWF_TMO_EN - when defined, a CWF write stalled by
//               the full flag for TMO_CYCLES cycles is dropped with ack+err
//               and the sticky farb_cwf_tmo_err flag is raised.
// Revision    : 1.0 - initial release
//==============================================================================
module fcb_sfr_arb #(
   parameter int                ADDR_W     = 7,
   parameter int                DATA_W     = 8,
   parameter logic [ADDR_W-1:0] CWF_ADDR   = ADDR_W'(7'h20),
   parameter int                TMO_CYCLES = 255
) (
   input  wire logic    fcb_sys_clk,
   input  wire logic    fcb_sys_rst_n,
   fcb_sfr_arb_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SFR_WR = 3'd1,
      ST_SFR_RD = 3'd2,
      ST_RD_CAP = 3'd3,
      ST_RD_ACK = 3'd4,
      ST_CWF_WR = 3'd5
   } state_t;

   // the stall counter is 8 bits wide, so the limit must fit in it
   generate
      if (TMO_CYCLES < 1 || TMO_CYCLES > 255) begin : g_tmo_range_chk
         $error("fcb_sfr_arb: TMO_CYCLES must be within 1..255");
      end
   endgenerate

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_last_gnt;   // 0 = r0 served last, 1 = r1 served last
   logic              r_owner;      // requester of the transaction in flight
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rd_data;

   logic              w_req_any;
   logic              w_gnt;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_grant_vld;
   logic              w_done;       // owner ack this cycle
   logic              w_wr_en;
   logic              w_rd_en;
   logic              w_cwf_wr_en;

`ifdef FCB_SFR_ARB_CWF_TMO_EN
   localparam logic [7:0] c_tmo_last = 8'(TMO_CYCLES - 1);
   logic [7:0]        r_tmo_cnt;    // full cycles seen in the current CWF_WR
   logic              r_tmo_err;
   logic              w_drop;
`endif

   // Requester selection: a lone request wins; on a tie the requester that
   // was not served last wins. r_last_gnt resets to 1 so r0 takes the first tie.
   always_comb begin
      w_req_any   = bus.r0_req | bus.r1_req;
      w_gnt       = (bus.r0_req & bus.r1_req) ? ~r_last_gnt : bus.r1_req;
      w_sel_we    = w_gnt ? bus.r1_we    : bus.r0_we;
      w_sel_addr  = w_gnt ? bus.r1_addr  : bus.r0_addr;
      w_sel_wdata = w_gnt ? bus.r1_wdata : bus.r0_wdata;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_vld = 1'b0;
      w_done      = 1'b0;
      w_wr_en     = 1'b0;
      w_rd_en     = 1'b0;
      w_cwf_wr_en = 1'b0;
`ifdef FCB_SFR_ARB_CWF_TMO_EN
      w_drop      = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_req_any) begin
               w_grant_vld = 1'b1;
               // a read of CWF_ADDR is an ordinary SFR read
               if (!w_sel_we)
                  w_state_nxt = ST_SFR_RD;
               else if (w_sel_addr == CWF_ADDR)
                  w_state_nxt = ST_CWF_WR;
               else
                  w_state_nxt = ST_SFR_WR;
            end
         end
         ST_SFR_WR: begin
            w_wr_en     = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         ST_SFR_RD: begin
            w_rd_en     = 1'b1;
            w_state_nxt = ST_RD_CAP;
         end
         ST_RD_CAP: begin
            w_state_nxt = ST_RD_ACK;
         end
         ST_RD_ACK: begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         ST_CWF_WR: begin
            // full is looked at combinationally so the write issues in the
            // very cycle the FIFO frees up
            if (!bus.frfu_cwf_full) begin
               w_cwf_wr_en = 1'b1;
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
`ifdef FCB_SFR_ARB_CWF_TMO_EN
            else if (r_tmo_cnt == c_tmo_last) begin
               w_drop      = 1'b1;
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
`endif
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge fcb_sys_clk) begin
      if (!fcb_sys_rst_n) begin
         r_state    <= ST_IDLE;
         r_last_gnt <= 1'b1;
         r_owner    <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rd_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         // direction is carried by the state, so only owner/addr/data latch
         if (w_grant_vld) begin
            r_last_gnt <= w_gnt;
            r_owner    <= w_gnt;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
         end
         if (r_state == ST_RD_CAP)
            r_rd_data <= bus.frfu_sfr_rd_data;
      end
   end

`ifdef FCB_SFR_ARB_CWF_TMO_EN
   always_ff @(posedge fcb_sys_clk) begin
      if (!fcb_sys_rst_n) begin
         r_tmo_cnt <= '0;
         r_tmo_err <= 1'b0;
      end else begin
         if (w_grant_vld)
            r_tmo_cnt <= '0;
         else if (r_state == ST_CWF_WR && bus.frfu_cwf_full)
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
         if (w_drop)
            r_tmo_err <= 1'b1;
      end
   end

   assign bus.r0_err           = w_drop & ~r_owner;
   assign bus.r1_err           = w_drop &  r_owner;
   assign bus.farb_cwf_tmo_err = r_tmo_err;
`else
   assign bus.r0_err           = 1'b0;
   assign bus.r1_err           = 1'b0;
   assign bus.farb_cwf_tmo_err = 1'b0;
`endif

   assign bus.r0_ack                = w_done & ~r_owner;
   assign bus.r1_ack                = w_done &  r_owner;
   assign bus.rd_data               = r_rd_data;
   assign bus.farb_frfu_wr_en       = w_wr_en;
   assign bus.farb_frfu_wr_addr     = r_addr;
   assign bus.farb_frfu_wr_data     = r_wdata;
   assign bus.farb_frfu_rd_en       = w_rd_en;
   assign bus.farb_frfu_rd_addr     = r_addr;
   assign bus.farb_frfu_cwf_wr_en   = w_cwf_wr_en;
   assign bus.farb_frfu_cwf_wr_data = r_wdata;
   assign bus.farb_busy             = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fcb_sfr_arb.sv
`default_nettype none
//==============================================================================
// Module      : tb_fcb_sfr_arb
// Description : Self-checking bench for fcb_sfr_arb. Directed steps for the
//               write, read, round-robin, CWF stall, CWF timeout and
//               mid-transaction reset cases, then randomized traffic. Every
//               cycle is compared against a transaction-level model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_fcb_sfr_arb;
   localparam int TMO   = 4;
`ifdef FCB_SFR_ARB_CWF_TMO_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif
   localparam int STALL = TMO_ON ? 3 : 5;
   localparam int K_WR  = 0;
   localparam int K_RD  = 1;
   localparam int K_CWF = 2;

   logic fcb_sys_clk;
   logic fcb_sys_rst_n;
   fcb_sfr_arb_if #(.ADDR_W(7), .DATA_W(8)) bus ();

   fcb_sfr_arb #(
      .ADDR_W    (7),
      .DATA_W    (8),
      .CWF_ADDR  (7'h20),
      .TMO_CYCLES(TMO)
   ) dut (
      .fcb_sys_clk  (fcb_sys_clk),
      .fcb_sys_rst_n(fcb_sys_rst_n),
      .bus          (bus.slave)
   );

   initial fcb_sys_clk = 1'b0;
   always #5 fcb_sys_clk = ~fcb_sys_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // transaction-level model
   bit       m_active, m_own, m_last, m_tmo;
   int       m_kind, m_phase, m_fcnt;
   bit [6:0] m_addr;
   bit [7:0] m_wdata, m_rd;

   // per-cycle snapshot of DUT outputs for directed checks
   logic       s_wr, s_cwf, s_rd, s_ack0, s_ack1, s_err1, s_busy, s_tmo;
   logic [7:0] s_rd_data, s_wr_data, s_cwf_data;
   logic [6:0] s_wr_addr, s_rd_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_own = 0; m_last = 1; m_tmo = 0;
      m_kind = K_WR; m_phase = 0; m_fcnt = 0;
      m_addr = '0; m_wdata = '0; m_rd = '0;
   endtask

   // Evaluate one cycle at the falling edge: compare, snapshot, advance model.
   task automatic check_cycle();
      bit e_wr, e_rd, e_cwf, done, drop, was_idle;
      bit [7:0] rd_nxt;
      e_wr = 0; e_rd = 0; e_cwf = 0; done = 0; drop = 0;
      was_idle = !m_active;
      rd_nxt = m_rd;
      if (m_active) begin
         m_phase++;
         if (m_kind == K_WR) begin
            e_wr = 1; done = 1;
         end else if (m_kind == K_RD) begin
            if (m_phase == 1)      e_rd = 1;
            else if (m_phase == 2) rd_nxt = bus.frfu_sfr_rd_data;
            else                   done = 1;
         end else if (!bus.frfu_cwf_full) begin
            e_cwf = 1; done = 1;
         end else begin
            m_fcnt++;
            if (TMO_ON && m_fcnt == TMO) begin
               done = 1; drop = 1;
            end
         end
      end
      chk("wr_en",    bus.farb_frfu_wr_en,       e_wr);
      chk("rd_en",    bus.farb_frfu_rd_en,       e_rd);
      chk("cwf_wr_en",bus.farb_frfu_cwf_wr_en,   e_cwf);
      chk("r0_ack",   bus.r0_ack,                done && !m_own);
      chk("r1_ack",   bus.r1_ack,                done &&  m_own);
      chk("r0_err",   bus.r0_err,                drop && !m_own);
      chk("r1_err",   bus.r1_err,                drop &&  m_own);
      chk("busy",     bus.farb_busy,             m_active);
      chk("tmo_err",  bus.farb_cwf_tmo_err,      m_tmo);
      chk("rd_data",  bus.rd_data,               m_rd);
      chk("wr_addr",  bus.farb_frfu_wr_addr,     m_addr);
      chk("rd_addr",  bus.farb_frfu_rd_addr,     m_addr);
      chk("wr_data",  bus.farb_frfu_wr_data,     m_wdata);
      chk("cwf_data", bus.farb_frfu_cwf_wr_data, m_wdata);
      s_wr = bus.farb_frfu_wr_en; s_rd = bus.farb_frfu_rd_en; s_cwf = bus.farb_frfu_cwf_wr_en;
      s_ack0 = bus.r0_ack; s_ack1 = bus.r1_ack; s_err1 = bus.r1_err;
      s_busy = bus.farb_busy; s_tmo = bus.farb_cwf_tmo_err; s_rd_data = bus.rd_data;
      s_wr_addr = bus.farb_frfu_wr_addr; s_wr_data = bus.farb_frfu_wr_data;
      s_rd_addr = bus.farb_frfu_rd_addr; s_cwf_data = bus.farb_frfu_cwf_wr_data;
      if (!fcb_sys_rst_n) begin
         model_reset();
      end else begin
         m_rd = rd_nxt;
         if (drop) m_tmo = 1;
         if (done) m_active = 0;
         if (was_idle && (bus.r0_req || bus.r1_req)) begin
            // lone request wins; on a tie the one not served last wins
            if (bus.r0_req && bus.r1_req) m_own = (m_last == 0);
            else                          m_own = bus.r1_req;
            m_last   = m_own;
            m_addr   = m_own ? bus.r1_addr  : bus.r0_addr;
            m_wdata  = m_own ? bus.r1_wdata : bus.r0_wdata;
            if (!(m_own ? bus.r1_we : bus.r0_we)) m_kind = K_RD;
            else if (m_addr == 7'h20)              m_kind = K_CWF;
            else                                   m_kind = K_WR;
            m_active = 1; m_phase = 0; m_fcnt = 0;
         end
      end
   endtask

   // inputs change 1 time unit after the rising edge; checks on the falling edge
   task automatic tick();
      @(negedge fcb_sys_clk);
      check_cycle();
      @(posedge fcb_sys_clk);
      #1;
   endtask

   task automatic do_reset();
      fcb_sys_rst_n = 1'b0;
      bus.r0_req = 0; bus.r1_req = 0;
      repeat (2) @(posedge fcb_sys_clk);
      #1;
      fcb_sys_rst_n = 1'b1;
      model_reset();
   endtask

   task automatic set_req(input int r, input bit req, input bit we, input bit [6:0] a, input bit [7:0] d);
      if (r == 0) begin
         bus.r0_req = req; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
      end else begin
         bus.r1_req = req; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
      end
   endtask

   task automatic rand_req(input int r);
      bit [6:0] a;
      a = ($urandom_range(3) == 0) ? 7'h20 : 7'($urandom);
      set_req(r, $urandom_range(3) != 0, 1'($urandom), a, 8'($urandom));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      fcb_sys_rst_n = 1'b0;
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      bus.frfu_cwf_full = 0;
      bus.frfu_sfr_rd_data = 8'h00;
      do_reset();

      // reset state
      chk("rst_busy",    bus.farb_busy,           0);
      chk("rst_acks",    {bus.r0_ack, bus.r1_ack, bus.r0_err, bus.r1_err}, 0);
      chk("rst_strobes", {bus.farb_frfu_wr_en, bus.farb_frfu_rd_en, bus.farb_frfu_cwf_wr_en}, 0);
      chk("rst_rd_data", bus.rd_data,             0);
      chk("rst_tmo",     bus.farb_cwf_tmo_err,    0);
      chk("rst_addr",    bus.farb_frfu_wr_addr,   0);

      // r0 SFR write: ack two cycles after request
      set_req(0, 1, 1, 7'h05, 8'hA5);
      tick();
      tick();
      chk("w_wr_en",   s_wr,      1);
      chk("w_wr_addr", s_wr_addr, 7'h05);
      chk("w_wr_data", s_wr_data, 8'hA5);
      chk("w_ack0",    s_ack0,    1);
      chk("w_cwf",     s_cwf,     0);
      bus.r0_req = 0;
      tick();

      // r1 SFR read: ack in cycle 4 with captured data
      set_req(1, 1, 0, 7'h11, 8'h00);
      tick();
      tick();
      chk("r_rd_en",   s_rd,      1);
      chk("r_rd_addr", s_rd_addr, 7'h11);
      bus.frfu_sfr_rd_data = 8'h3C;
      tick();
      bus.frfu_sfr_rd_data = 8'hC3;
      tick();
      chk("r_ack1",    s_ack1,    1);
      chk("r_rd_data", s_rd_data, 8'h3C);
      bus.r1_req = 0;
      tick();
      tick();
      chk("r_rd_hold", s_rd_data, 8'h3C);

      // both requesting from reset: r0,r1,r0,r1 with an idle cycle between
      do_reset();
      set_req(0, 1, 1, 7'h01, 8'h11);
      set_req(1, 1, 1, 7'h02, 8'h22);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rr_ack0", s_ack0, (i == 1 || i == 5));
         chk("rr_ack1", s_ack1, (i == 3 || i == 7));
      end
      bus.r0_req = 0; bus.r1_req = 0;
      tick();

      // CWF write stalled by full, issued in the first not-full cycle
      set_req(0, 1, 1, 7'h20, 8'h77);
      bus.frfu_cwf_full = 1;
      tick();
      for (int i = 0; i < STALL; i++) begin
         tick();
         chk("cwf_stall_strobe", s_cwf,  0);
         chk("cwf_stall_ack",    s_ack0, 0);
      end
      bus.frfu_cwf_full = 0;
      tick();
      chk("cwf_wr_en", s_cwf,      1);
      chk("cwf_data",  s_cwf_data, 8'h77);
      chk("cwf_ack0",  s_ack0,     1);
      bus.r0_req = 0;
      tick();

      // CWF held full by r1
      set_req(1, 1, 1, 7'h20, 8'h66);
      bus.frfu_cwf_full = 1;
      tick();
`ifdef FCB_SFR_ARB_CWF_TMO_EN
      for (int i = 0; i < TMO - 1; i++) begin
         tick();
         chk("tmo_wait_ack", s_ack1, 0);
      end
      tick();
      chk("tmo_ack1",   s_ack1, 1);
      chk("tmo_err1",   s_err1, 1);
      chk("tmo_strobe", s_cwf,  0);
      bus.r1_req = 0;
      bus.frfu_cwf_full = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("tmo_sticky", s_tmo, 1);
      end
`else
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("stall_ack1", s_ack1, 0);
         chk("stall_tmo",  s_tmo,  0);
      end
      bus.frfu_cwf_full = 0;
      tick();
      chk("stall_done", s_ack1, 1);
      bus.r1_req = 0;
      tick();
`endif

      // reset during RD_CAP discards the read
      set_req(0, 1, 0, 7'h33, 8'h00);
      tick();
      tick();
      fcb_sys_rst_n = 1'b0;
      bus.frfu_sfr_rd_data = 8'h99;
      tick();
      fcb_sys_rst_n = 1'b1;
      bus.r0_req = 0;
      tick();
      chk("rstmid_ack0", s_ack0,    0);
      chk("rstmid_busy", s_busy,    0);
      chk("rstmid_rd",   s_rd_data, 0);
      chk("rstmid_tmo",  s_tmo,     0);
      set_req(1, 1, 1, 7'h07, 8'h5A);
      tick();
      tick();
      chk("rstmid_new_ack",  s_ack1,    1);
      chk("rstmid_new_addr", s_wr_addr, 7'h07);
      bus.r1_req = 0;
      tick();

      // randomized traffic, including early request drops
      for (int c = 0; c < 1500; c++) begin
         if (!bus.r0_req || s_ack0)         rand_req(0);
         else if ($urandom_range(31) == 0)  bus.r0_req = 0;
         if (!bus.r1_req || s_ack1)         rand_req(1);
         else if ($urandom_range(31) == 0)  bus.r1_req = 0;
         bus.frfu_cwf_full    = ($urandom_range(2) == 0);
         bus.frfu_sfr_rd_data = 8'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fcb_sfr_arb.md
Name: fcb_sfr_arb

Overview:
- Arbitrates the FCB SFR register port and the config write FIFO (CWF) port between two requesters: the SPI-slave bridge (r0) and the MCU/fmic register path (r1).
- Serialises one transaction at a time, using round-robin on contention.
- Routes writes to the CWF data address to the CWF, stalling on the FIFO full flag; all other writes and all reads go to the SFR port.

Parameters:
- ADDR_W, 7, SFR address width
- DATA_W, 8, SFR/CWF data width
- CWF_ADDR, 7'h20, write address redirected to the CWF
- TMO_CYCLES, 255, CWF stall limit (used only with the optional feature), range 1..255

Ports:
- fcb_sys_clk  in  1  FCB system clock
- fcb_sys_rst_n  in  1  reset, synchronous, active-low
- r0_req  in  1  SPI-slave bridge request; held with fields stable until r0_ack
- r0_we  in  1  1=write, 0=read
- r0_addr  in  ADDR_W  address
- r0_wdata  in  DATA_W  write data
- r0_ack  out  1  one-cycle completion pulse
- r0_err  out  1  qualifies r0_ack: transaction dropped on timeout
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_err  same as r0, for the MCU/fmic requester
- rd_data  out  DATA_W  read data; valid with a read ack
- frfu_sfr_rd_data  in  DATA_W  SFR read data, valid one cycle after rd_en
- frfu_cwf_full  in  1  CWF full flag
- farb_frfu_wr_en  out  1  SFR write strobe
- farb_frfu_wr_addr  out  ADDR_W  SFR write address
- farb_frfu_wr_data  out  DATA_W  SFR write data
- farb_frfu_rd_en  out  1  SFR read strobe
- farb_frfu_rd_addr  out  ADDR_W  SFR read address
- farb_frfu_cwf_wr_en  out  1  CWF write strobe
- farb_frfu_cwf_wr_data  out  DATA_W  CWF write data
- farb_busy  out  1  state != IDLE
- farb_cwf_tmo_err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low on fcb_sys_rst_n.
- Reset values (after the reset edge):
  - state=IDLE, last_gnt=1
  - all strobes, acks, errs, farb_busy and farb_cwf_tmo_err = 0
  - rd_data=0, latched addr/data=0
- Reset mid-transaction: the transaction is discarded with no ack.
- Address and data outputs: driven from the latched transaction registers, and remain stable when their strobe is low.
- State machine:
  - IDLE: if any req is high, grant one requester and latch owner, we, addr and wdata. Next state:
    - we=1 and addr!=CWF_ADDR -> SFR_WR
    - we=1 and addr==CWF_ADDR -> CWF_WR
    - we=0 -> SFR_RD (a read of CWF_ADDR is an ordinary SFR read)
  - SFR_WR: farb_frfu_wr_en=1 and owner ack=1 for one cycle -> IDLE. Write latency: req high to ack = 2 cycles.
  - SFR_RD: farb_frfu_rd_en=1 -> RD_CAP.
  - RD_CAP: rd_data <= frfu_sfr_rd_data -> RD_ACK.
  - RD_ACK: owner ack=1 -> IDLE. Read latency = 4 cycles. rd_data holds until the next RD_CAP.
  - CWF_WR:
    - frfu_cwf_full=0 in this cycle: farb_frfu_cwf_wr_en=1, ack -> IDLE.
    - frfu_cwf_full=1: stay in CWF_WR with no strobe.
    - Full deasserting in the same cycle issues the write that cycle.
- Arbitration:
  - Only one req high -> that requester is granted.
  - Both high -> grant the requester that is not last_gnt; last_gnt updates on grant.
  - Out of reset, r0 wins the first tie.
  - Back-to-back: a req held high after its ack is re-arbitrated in the following IDLE cycle, so the IDLE cycle occurs between every pair of transactions.
  - The non-owner's ack and err stay 0.
- Protocol violation: if req drops before ack, the latched transaction still completes and the ack pulses anyway.
- Strobes are mutually exclusive, and at most one ack is high per cycle.

Optional Feature:
- Macro: FCB_SFR_ARB_CWF_TMO_EN.
- Defined:
  - An 8-bit stall counter clears on entry to CWF_WR and increments each cycle frfu_cwf_full=1.
  - When the counter reaches TMO_CYCLES while still full, the write is dropped: no strobe; owner ack=1 and owner err=1 in the same cycle; farb_cwf_tmo_err is set; next state IDLE.
  - farb_cwf_tmo_err stays set until reset.
- Not defined:
  - CWF_WR stalls indefinitely while full.
  - r0_err, r1_err and farb_cwf_tmo_err are tied 0, and no counter logic is present.

Test Plan:
- r0 write addr=7'h05, data=8'hA5 -> cycle 2: wr_en=1, wr_addr=05, wr_data=A5, r0_ack=1. No cwf strobe.
- r1 read addr=7'h11 with frfu_sfr_rd_data=8'h3C the cycle after rd_en -> r1_ack in cycle 4 with rd_data=3C. rd_data holds afterwards.
- r0 and r1 both request continuously from reset -> grant order r0,r1,r0,r1. Exactly one ack per transaction, with one IDLE cycle between transactions.
- r0 write addr=7'h20, data=8'h77 with full=1 for 5 cycles -> no strobe while full. cwf_wr_en=1 with data 77 in the first full=0 cycle, together with r0_ack.
- FCB_SFR_ARB_CWF_TMO_EN, TMO_CYCLES=4, full held high -> r1_ack=1, r1_err=1 and no cwf strobe; farb_cwf_tmo_err=1 until reset.
- Reset asserted in RD_CAP -> next edge: state IDLE, no ack, all outputs at reset values; a new request afterwards completes normally.
